// File: rtl/mem_access.sv
// mem_access: memory-access stage between EX and write-back; aligns store lanes,
//   extends loads, reports misaligned/illegal/bus-timeout faults.
// Latency: 1 cycle for pass-through and faults, 2 + wait cycles for memory ops.
// Backpressure: ready_in drops for the whole REQ phase; write-back never stalls.
// Ports: EX side (valid_in/ready_in, MemRead, MemWrite, func3, ALUresult, rs2,
//   rd_in, RegWrite), data-memory req/ack port (dm_*), write-back side
//   (valid_out pulse, result, rd_out, reg_we, fault).
module mem_access #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        valid_in,
   output logic        ready_in,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [2:0]  func3,
   input  logic [31:0] ALUresult,
   input  logic [31:0] rs2,
   input  logic [4:0]  rd_in,
   input  logic        RegWrite,
   output logic        dm_req,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   output logic [3:0]  dm_wstrb,
   input  logic [31:0] dm_rdata,
   input  logic        dm_ack,
   output logic        valid_out,
   output logic [31:0] result,
   output logic [4:0]  rd_out,
   output logic        reg_we,
   output logic [1:0]  fault
);

   typedef enum logic {IDLE, REQ} state_t;

   state_t      state, state_nxt;
   logic [31:0] addr_q, rs2_q;
   logic [2:0]  f3_q;
   logic        we_q, regwrite_q;
   logic [4:0]  rd_q;
   logic [31:0] tcnt, tcnt_nxt;

   logic        accept, illegal, misaligned;
   logic        done, done_reg_we;
   logic [31:0] done_result;
   logic [4:0]  done_rd;
   logic [1:0]  done_fault;
   logic [31:0] rshift, load_val;
   logic        in_req;

   assign in_req   = (state == REQ);
   assign ready_in = (state == IDLE);

   // Classification of the instruction being offered; only used at accept.
   assign illegal = (MemRead & MemWrite)
                  | (MemRead & ((func3 == 3'b011) | (func3 == 3'b110) | (func3 == 3'b111)))
                  | (MemWrite & (func3 >= 3'b011));
   assign misaligned = ((func3[1:0] == 2'b01) & ALUresult[0])
                     | ((func3 == 3'b010) & (ALUresult[1:0] != 2'b00));

   // Bring the addressed byte/halfword down to bit 0, then extend.
   assign rshift = dm_rdata >> {addr_q[1:0], 3'b000};
   always_comb begin
      load_val = dm_rdata;
      case (f3_q)
         3'b000:  load_val = {{24{rshift[7]}}, rshift[7:0]};
         3'b001:  load_val = {{16{rshift[15]}}, rshift[15:0]};
         3'b100:  load_val = {24'd0, rshift[7:0]};
         3'b101:  load_val = {16'd0, rshift[15:0]};
         default: load_val = dm_rdata;
      endcase
   end

   // Bus outputs derive from latched state, so they stay put until ack and
   // vanish as soon as the state register is cleared.
   always_comb begin
      dm_req   = in_req;
      dm_we    = in_req & we_q;
      dm_addr  = in_req ? {addr_q[31:2], 2'b00} : 32'd0;
      dm_wdata = 32'd0;
      dm_wstrb = 4'b0000;
      if (in_req && we_q) begin
         case (f3_q[1:0])
            2'b00: begin
               dm_wdata = {4{rs2_q[7:0]}};
               dm_wstrb = 4'b0001 << addr_q[1:0];
            end
            2'b01: begin
               dm_wdata = {2{rs2_q[15:0]}};
               dm_wstrb = 4'b0011 << {addr_q[1], 1'b0};
            end
            default: begin
               dm_wdata = rs2_q;
               dm_wstrb = 4'b1111;
            end
         endcase
      end
   end

   // Next state plus the write-back event for this cycle.
   always_comb begin
      state_nxt   = state;
      tcnt_nxt    = tcnt;
      accept      = 1'b0;
      done        = 1'b0;
      done_result = 32'd0;
      done_reg_we = 1'b0;
      done_fault  = 2'b00;
      done_rd     = rd_q;
      case (state)
         IDLE: begin
            tcnt_nxt = 32'd0;
            if (valid_in) begin
               accept  = 1'b1;
               done_rd = rd_in;
               if (!MemRead && !MemWrite) begin
                  done        = 1'b1;
                  done_result = ALUresult;
                  done_reg_we = RegWrite;
               end else if (illegal) begin
                  done       = 1'b1;
                  done_fault = 2'b10;
               end else if (misaligned) begin
                  done        = 1'b1;
                  done_fault  = 2'b01;
                  done_result = ALUresult;
               end else begin
                  state_nxt = REQ;
               end
            end
         end
         REQ: begin
            // An ack in the timeout cycle still completes the access normally.
            if (dm_ack) begin
               state_nxt = IDLE;
               done      = 1'b1;
               if (!we_q) begin
                  done_result = load_val;
                  done_reg_we = regwrite_q;
               end
            end else if ((TIMEOUT != 0) && (tcnt == 32'(TIMEOUT - 1))) begin
               state_nxt  = IDLE;
               done       = 1'b1;
               done_fault = 2'b11;
            end else begin
               tcnt_nxt = tcnt + 32'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state <= IDLE;
         tcnt  <= 32'd0;
      end else begin
         state <= state_nxt;
         tcnt  <= tcnt_nxt;
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         addr_q     <= 32'd0;
         rs2_q      <= 32'd0;
         f3_q       <= 3'd0;
         we_q       <= 1'b0;
         rd_q       <= 5'd0;
         regwrite_q <= 1'b0;
      end else if (accept) begin
         addr_q     <= ALUresult;
         rs2_q      <= rs2;
         f3_q       <= func3;
         we_q       <= MemWrite;
         rd_q       <= rd_in;
         regwrite_q <= RegWrite;
      end
   end

   // Write-back fields hold between pulses; only valid_out is a pulse.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         valid_out <= 1'b0;
         result    <= 32'd0;
         rd_out    <= 5'd0;
         reg_we    <= 1'b0;
         fault     <= 2'b00;
      end else begin
         valid_out <= done;
         if (done) begin
            result <= done_result;
            rd_out <= done_rd;
            reg_we <= done_reg_we;
            fault  <= done_fault;
         end
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed stimulus with a scoreboard queue and a free-running
//   monitor that checks every valid_out pulse (value and arrival cycle).
// Memory acks are driven by the stimulus task itself, cycle by cycle.
module tb_mem_access;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic        valid_in = 1'b0;
   logic        ready_in;
   logic        MemRead = 1'b0;
   logic        MemWrite = 1'b0;
   logic [2:0]  func3 = 3'd0;
   logic [31:0] ALUresult = 32'd0;
   logic [31:0] rs2 = 32'd0;
   logic [4:0]  rd_in = 5'd0;
   logic        RegWrite = 1'b0;
   logic        dm_req, dm_we;
   logic [31:0] dm_addr, dm_wdata;
   logic [3:0]  dm_wstrb;
   logic [31:0] dm_rdata = 32'd0;
   logic        dm_ack = 1'b0;
   logic        valid_out;
   logic [31:0] result;
   logic [4:0]  rd_out;
   logic        reg_we;
   logic [1:0]  fault;

   mem_access #(.TIMEOUT(4)) dut (
      .clk(clk), .clr(clr), .valid_in(valid_in), .ready_in(ready_in),
      .MemRead(MemRead), .MemWrite(MemWrite), .func3(func3),
      .ALUresult(ALUresult), .rs2(rs2), .rd_in(rd_in), .RegWrite(RegWrite),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_wstrb(dm_wstrb), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
      .valid_out(valid_out), .result(result), .rd_out(rd_out),
      .reg_we(reg_we), .fault(fault)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] result;
      logic [4:0]  rd;
      logic        we;
      logic [1:0]  fault;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every valid_out pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (!clr && valid_out) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_valid_out actual=1 expected=0 (t=%0t)", $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("wb_cycle", 32'(cyc), 32'(e.cyc));
            chk("wb_result", result, e.result);
            chk("wb_rd", {27'd0, rd_out}, {27'd0, e.rd});
            chk("wb_reg_we", {31'd0, reg_we}, {31'd0, e.we});
            chk("wb_fault", {30'd0, fault}, {30'd0, e.fault});
         end
      end
   end

   // Called at posedge+1. nreq = cycles the request should stay up;
   // ack=1 acks in the last of them, ack=0 lets it time out.
   task automatic issue(
      input logic mr, input logic mw, input logic [2:0] f3,
      input logic [31:0] alu, input logic [31:0] r2, input logic [4:0] rd,
      input logic rw, input int nreq, input logic ack, input logic [31:0] rdata,
      input logic [31:0] e_addr, input logic [31:0] e_wdata, input logic [3:0] e_wstrb,
      input logic [31:0] e_res, input logic e_we, input logic [1:0] e_fault);
      int acc;
      exp_t e;
      chk("ready_before_accept", {31'd0, ready_in}, 32'd1);
      valid_in = 1'b1; MemRead = mr; MemWrite = mw; func3 = f3;
      ALUresult = alu; rs2 = r2; rd_in = rd; RegWrite = rw;
      @(posedge clk); #1;
      valid_in = 1'b0;
      acc = cyc;
      e.result = e_res; e.rd = rd; e.we = e_we; e.fault = e_fault; e.cyc = acc + nreq;
      sb.push_back(e);
      if (nreq == 0) chk("no_dm_req", {31'd0, dm_req}, 32'd0);
      for (int i = 0; i < nreq; i++) begin
         chk("dm_req", {31'd0, dm_req}, 32'd1);
         chk("ready_in_req", {31'd0, ready_in}, 32'd0);
         chk("dm_we", {31'd0, dm_we}, {31'd0, mw});
         chk("dm_addr", dm_addr, e_addr);
         chk("dm_wdata", dm_wdata, e_wdata);
         chk("dm_wstrb", {28'd0, dm_wstrb}, {28'd0, e_wstrb});
         dm_rdata = rdata;
         dm_ack = ack && (i == nreq - 1);
         @(posedge clk); #1;
      end
      dm_ack = 1'b0;
      if (nreq != 0) chk("dm_req_dropped", {31'd0, dm_req}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      #3;
      chk("rst_dm_req", {31'd0, dm_req}, 32'd0);
      chk("rst_valid_out", {31'd0, valid_out}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_fault", {30'd0, fault}, 32'd0);
      chk("rst_reg_we", {31'd0, reg_we}, 32'd0);
      chk("rst_ready_in", {31'd0, ready_in}, 32'd1);
      @(posedge clk); @(posedge clk); #1;
      clr = 1'b0;

      //     mr  mw  f3    alu           rs2           rd  rw n ack rdata          addr          wdata         strb     res           we fault
      dm_ack = 1'b1; // ack while idle must be ignored
      issue(0, 0, 3'b000, 32'h1234_5678, 32'h0,        5,  1, 0, 0, 32'h0,          32'h0,        32'h0,        4'b0000, 32'h1234_5678, 1, 2'b00);
      issue(1, 0, 3'b000, 32'h0000_0103, 32'h0,        7,  1, 1, 1, 32'h80FF_7F01,  32'h100,      32'h0,        4'b0000, 32'hFFFF_FF80, 1, 2'b00);
      issue(1, 0, 3'b100, 32'h0000_0103, 32'h0,        8,  1, 1, 1, 32'h80FF_7F01,  32'h100,      32'h0,        4'b0000, 32'h0000_0080, 1, 2'b00);
      issue(1, 0, 3'b001, 32'h0000_0102, 32'h0,        9,  1, 1, 1, 32'h80FF_7F01,  32'h100,      32'h0,        4'b0000, 32'hFFFF_80FF, 1, 2'b00);
      issue(1, 0, 3'b101, 32'h0000_0102, 32'h0,        10, 1, 1, 1, 32'h80FF_7F01,  32'h100,      32'h0,        4'b0000, 32'h0000_80FF, 1, 2'b00);
      issue(1, 0, 3'b010, 32'h0000_0100, 32'h0,        11, 1, 1, 1, 32'h80FF_7F01,  32'h100,      32'h0,        4'b0000, 32'h80FF_7F01, 1, 2'b00);
      issue(1, 0, 3'b100, 32'h0000_0100, 32'h0,        12, 1, 1, 1, 32'h80FF_7F01,  32'h100,      32'h0,        4'b0000, 32'h0000_0001, 1, 2'b00);
      issue(0, 1, 3'b000, 32'h0000_0101, 32'hAABBCCDD, 13, 1, 1, 1, 32'h0,          32'h100,      32'hDDDDDDDD, 4'b0010, 32'h0,         0, 2'b00);
      issue(0, 1, 3'b001, 32'h0000_0102, 32'hAABBCCDD, 14, 1, 1, 1, 32'h0,          32'h100,      32'hCCDDCCDD, 4'b1100, 32'h0,         0, 2'b00);
      issue(0, 1, 3'b010, 32'h0000_0104, 32'hAABBCCDD, 15, 1, 1, 1, 32'h0,          32'h104,      32'hAABBCCDD, 4'b1111, 32'h0,         0, 2'b00);
      // three wait states; the ack lands in the would-be timeout cycle and wins
      issue(1, 0, 3'b010, 32'h0000_0108, 32'h0,        16, 1, 4, 1, 32'h1122_3344,  32'h108,      32'h0,        4'b0000, 32'h1122_3344, 1, 2'b00);
      issue(1, 0, 3'b010, 32'h0000_0102, 32'h0,        17, 1, 0, 0, 32'h0,          32'h0,        32'h0,        4'b0000, 32'h0000_0102, 0, 2'b01);
      issue(0, 1, 3'b001, 32'h0000_0103, 32'h0,        18, 1, 0, 0, 32'h0,          32'h0,        32'h0,        4'b0000, 32'h0000_0103, 0, 2'b01);
      issue(1, 0, 3'b011, 32'h0000_0100, 32'h0,        19, 1, 0, 0, 32'h0,          32'h0,        32'h0,        4'b0000, 32'h0,         0, 2'b10);
      issue(1, 1, 3'b010, 32'h0000_0100, 32'h0,        20, 1, 0, 0, 32'h0,          32'h0,        32'h0,        4'b0000, 32'h0,         0, 2'b10);
      issue(0, 1, 3'b011, 32'h0000_0100, 32'h0,        21, 1, 0, 0, 32'h0,          32'h0,        32'h0,        4'b0000, 32'h0,         0, 2'b10);
      issue(1, 0, 3'b010, 32'h0000_0200, 32'h0,        22, 1, 4, 0, 32'h0,          32'h200,      32'h0,        4'b0000, 32'h0,         0, 2'b11);
      repeat (2) @(posedge clk);
      #1;

      // Reset in the middle of a pending load: request vanishes, no write-back.
      valid_in = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; func3 = 3'b010;
      ALUresult = 32'h300; rd_in = 5'd23; RegWrite = 1'b1;
      @(posedge clk); #1;
      valid_in = 1'b0;
      chk("clr_pre_dm_req", {31'd0, dm_req}, 32'd1);
      @(posedge clk); #2;
      clr = 1'b1;
      #1;
      chk("clr_dm_req", {31'd0, dm_req}, 32'd0);
      chk("clr_valid_out", {31'd0, valid_out}, 32'd0);
      chk("clr_dm_addr", dm_addr, 32'd0);
      #1;
      clr = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("post_clr_dm_req", {31'd0, dm_req}, 32'd0);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
